// File: rtl/conv_net_pkg.sv
// Shared definitions for the convolution network frame controller and its
// datapath layers: sequencer state encoding, error codes and the derived
// frame geometry helpers.
package conv_net_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_CONV = 3'd2,
    ST_POOL = 3'd3,
    ST_ERR  = 3'd4
  } seq_state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_COUNT   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_STROBE  = 2'd3;

  // Number of input pixels in one frame.
  function automatic int calc_npix(input int w, input int h);
    return w * h;
  endfunction

  // Number of conv outputs (valid convolution, no padding).
  function automatic int calc_nconv(input int w, input int h, input int k);
    return (w - k + 1) * (h - k + 1);
  endfunction

  // Number of pooled outputs; partial pool windows at the edge are dropped.
  function automatic int calc_npool(input int w, input int h, input int k, input int p);
    return ((w - k + 1) / p) * ((h - k + 1) / p);
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Progress watchdog: counts enabled cycles since the last clear and flags
// when the count sits at its terminal value. The owner decides whether that
// cycle really expires (it may still see progress in the same cycle).
module seq_watchdog #(
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic at_limit
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_reg;

  // Cycle counter: clear wins, then count while enabled, holding at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != LIMIT)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign at_limit = enable && (count_reg == LIMIT);

endmodule

// File: rtl/conv_layer_sequencer.sv
// Frame-level controller for the convolution network: gates the input pixel
// stream, starts the conv layer, counts feature-map writes, launches the
// max/ReLU pass, counts pooled outputs and reports completion or errors.
module conv_layer_sequencer
  import conv_net_pkg::*;
#(
  parameter int IMG_W   = 28,
  parameter int IMG_H   = 28,
  parameter int KERNEL  = 3,
  parameter int POOL    = 2,
  parameter int TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic       pixel_valid,
  output logic       pixel_ready,
  output logic       conv_start,
  input  logic       layer_0_ready,
  input  logic       layer_1_ready,
  input  logic       layer_1_write_complete,
  output logic       relu_begin,
  input  logic       layer_2_data_available,
  input  logic       layer_2_ready,
  output logic       busy,
  output logic       frame_done,
  output logic       error,
  output logic [1:0] err_code,
  output logic [9:0] pix_count,
  output logic [9:0] conv_count,
  output logic [7:0] pool_count
);

  localparam int NPIX  = calc_npix(IMG_W, IMG_H);
  localparam int NCONV = calc_nconv(IMG_W, IMG_H, KERNEL);
  localparam int NPOOL = calc_npool(IMG_W, IMG_H, KERNEL, POOL);

  localparam logic [9:0] NPIX_W    = 10'(NPIX);
  localparam logic [9:0] NPIX_LAST = 10'(NPIX - 1);
  localparam logic [9:0] NCONV_W   = 10'(NCONV);
  localparam logic [7:0] NPOOL_W   = 8'(NPOOL);

  seq_state_t state_reg, state_next;
  logic [1:0] err_code_reg, err_code_next;
  logic [9:0] pix_count_reg, conv_count_reg;
  logic [7:0] pool_count_reg;
  logic       conv_start_reg, relu_begin_reg, frame_done_reg;

  logic       active;
  logic       pix_accept, conv_strobe, pool_strobe;
  logic       stray_strobe, conv_overflow, pool_overflow;
  logic       progress, wd_at_limit, timeout, wd_clear;
  logic       go_load;
  logic [9:0] pix_count_upd, conv_count_upd;
  logic [7:0] pool_count_upd;

  // The window-buffer primed flag is observed only; no control depends on it.
  logic unused_layer_0;
  assign unused_layer_0 = layer_0_ready;

  assign active      = (state_reg == ST_LOAD) || (state_reg == ST_CONV) ||
                       (state_reg == ST_POOL);
  assign pixel_ready = (state_reg == ST_LOAD) && (pix_count_reg < NPIX_W);
  assign pix_accept  = pixel_ready && pixel_valid;
  assign conv_strobe = active && layer_1_ready;
  assign pool_strobe = (state_reg == ST_POOL) && layer_2_data_available;

  // Strobes that have no meaning in the current state.
  assign stray_strobe =
      ((state_reg == ST_IDLE) && (layer_1_ready || layer_2_data_available)) ||
      (((state_reg == ST_LOAD) || (state_reg == ST_CONV)) && layer_2_data_available);

  assign conv_overflow = conv_strobe && (conv_count_reg >= NCONV_W);
  assign pool_overflow = pool_strobe && (pool_count_reg >= NPOOL_W);

  // Counter values including this cycle's strobe, saturating at all-ones.
  assign pix_count_upd  = (pix_accept  && (pix_count_reg  != '1)) ? pix_count_reg  + 10'd1 : pix_count_reg;
  assign conv_count_upd = (conv_strobe && (conv_count_reg != '1)) ? conv_count_reg + 10'd1 : conv_count_reg;
  assign pool_count_upd = (pool_strobe && (pool_count_reg != '1)) ? pool_count_reg + 8'd1  : pool_count_reg;

  // Timeout only fires on a cycle with no progress; a state change in the
  // same cycle is taken first by the next-state logic below.
  assign progress = pix_accept || layer_1_ready || layer_2_data_available;
  assign timeout  = wd_at_limit && !progress;
  assign wd_clear = progress || (state_next != state_reg);
  assign go_load  = (state_reg == ST_IDLE) && (state_next == ST_LOAD);

  seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .enable   (active),
    .clear    (wd_clear),
    .at_limit (wd_at_limit)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state, error code and level outputs; error checks in priority 3, 1, 2.
  always_comb begin
    state_next    = state_reg;
    err_code_next = err_code_reg;
    busy          = (state_reg != ST_IDLE);
    error         = (state_reg == ST_ERR);
    unique case (state_reg)
      ST_IDLE: begin
        if (stray_strobe) begin
          state_next    = ST_ERR;
          err_code_next = ERR_STROBE;
        end else if (frame_start) begin
          state_next    = ST_LOAD;
          err_code_next = ERR_NONE;
        end
      end
      ST_LOAD: begin
        if (stray_strobe) begin
          state_next    = ST_ERR;
          err_code_next = ERR_STROBE;
        end else if (conv_overflow) begin
          state_next    = ST_ERR;
          err_code_next = ERR_COUNT;
        end else if (pix_accept && (pix_count_reg == NPIX_LAST)) begin
          state_next = ST_CONV;
        end else if (timeout) begin
          state_next    = ST_ERR;
          err_code_next = ERR_TIMEOUT;
        end
      end
      ST_CONV: begin
        if (stray_strobe) begin
          state_next    = ST_ERR;
          err_code_next = ERR_STROBE;
        end else if (conv_overflow) begin
          state_next    = ST_ERR;
          err_code_next = ERR_COUNT;
        end else if (layer_1_write_complete) begin
          if (conv_count_upd == NCONV_W) begin
            state_next = ST_POOL;
          end else begin
            state_next    = ST_ERR;
            err_code_next = ERR_COUNT;
          end
        end else if (timeout) begin
          state_next    = ST_ERR;
          err_code_next = ERR_TIMEOUT;
        end
      end
      ST_POOL: begin
        if (conv_overflow || pool_overflow) begin
          state_next    = ST_ERR;
          err_code_next = ERR_COUNT;
        end else if (layer_2_ready) begin
          if (pool_count_upd == NPOOL_W) begin
            state_next = ST_IDLE;
          end else begin
            state_next    = ST_ERR;
            err_code_next = ERR_COUNT;
          end
        end else if (timeout) begin
          state_next    = ST_ERR;
          err_code_next = ERR_TIMEOUT;
        end
      end
      ST_ERR: begin
        state_next = ST_ERR;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Progress counters and error code; a new frame clears them all.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_count_reg  <= '0;
      conv_count_reg <= '0;
      pool_count_reg <= '0;
      err_code_reg   <= ERR_NONE;
    end else if (go_load) begin
      pix_count_reg  <= '0;
      conv_count_reg <= '0;
      pool_count_reg <= '0;
      err_code_reg   <= ERR_NONE;
    end else begin
      pix_count_reg  <= pix_count_upd;
      conv_count_reg <= conv_count_upd;
      pool_count_reg <= pool_count_upd;
      err_code_reg   <= err_code_next;
    end
  end

  // One-cycle pulses, each raised in the first cycle of the state it announces.
  always_ff @(posedge clk) begin
    if (rst) begin
      conv_start_reg <= 1'b0;
      relu_begin_reg <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      conv_start_reg <= go_load;
      relu_begin_reg <= (state_reg == ST_CONV) && (state_next == ST_POOL);
      frame_done_reg <= (state_reg == ST_POOL) && (state_next == ST_IDLE);
    end
  end

  assign conv_start = conv_start_reg;
  assign relu_begin = relu_begin_reg;
  assign frame_done = frame_done_reg;
  assign err_code   = err_code_reg;
  assign pix_count  = pix_count_reg;
  assign conv_count = conv_count_reg;
  assign pool_count = pool_count_reg;

endmodule
